// File: rtl/sram22_req_adapter_if.sv
// Request/response stream bundle between a client and sram22_req_adapter.
// The master drives requests and the response ready; the slave answers with ready and read data.
interface sram22_req_adapter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WMASK_WIDTH = 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram22_req_adapter.sv
// Stream-to-pin adapter for the 4096x8 single-port SRAM, with a credited response FIFO.
// Define SRAM22_REQ_ADAPTER_STATS_EN to add saturating rd_count/wr_count outputs.
module sram22_req_adapter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WMASK_WIDTH = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  sram22_req_adapter_if.slave    bus,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM22_REQ_ADAPTER_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pending_q;
  logic [OW-1:0]         occ;
  logic                  rd_credit;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  push;
  logic                  pop;

  // A read may enter only if its future FIFO slot is guaranteed, counting the one in flight;
  // a pop in this same cycle frees a slot early.
  assign occ       = OW'(count) + OW'(pending_q);
  assign rsp_fire  = bus.rsp_valid & bus.rsp_ready;
  assign rd_credit = (occ < OW'(RSP_DEPTH)) | ((occ == OW'(RSP_DEPTH)) & rsp_fire);
  assign bus.req_ready = rstb & (bus.req_we | rd_credit);
  assign req_fire  = bus.req_valid & bus.req_ready;

  assign sram_addr  = bus.req_addr;
  assign sram_din   = bus.req_wdata;
  assign sram_wmask = bus.req_wmask;
  assign sram_we    = req_fire & bus.req_we;

  assign push          = pending_q;
  assign pop           = rsp_fire;
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_rdata = fifo_mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pending_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      pending_q <= req_fire & ~bus.req_we;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // dout still holds the previous edge's read here, even if this edge writes the macro.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstb)
    !(push && !pop && (count == CW'(RSP_DEPTH))));

`ifdef SRAM22_REQ_ADAPTER_STATS_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (req_fire && !bus.req_we && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (req_fire &&  bus.req_we && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Directed bench for sram22_req_adapter against a behavioural 4096x8 SRAM model.
// Defining SRAM22_REQ_ADAPTER_STATS_EN also exercises the statistics counters.
module tb_sram22_req_adapter;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int MW = 1;

  logic          clk = 1'b0;
  logic          rstb;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] mem [4096];
`ifdef SRAM22_REQ_ADAPTER_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram22_req_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  sram22_req_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(2)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .bus        (bus),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
`ifdef SRAM22_REQ_ADAPTER_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  // Macro model: 1-cycle read latency, dout goes unknown on a write edge.
  always @(posedge clk) begin
    if (sram_we && sram_wmask[0]) mem[sram_addr] <= sram_din;
    sram_dout <= sram_we ? 'x : mem[sram_addr];
  end

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_ready;
    logic          exp_ready;
    logic          exp_rv;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic w, input logic [MW-1:0] m,
                              input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr,
                              input logic er, input logic ev, input logic [DW-1:0] ed);
    vec_t t;
    t.valid = v; t.we = w; t.wmask = m; t.addr = a; t.wdata = d; t.rsp_ready = rr;
    t.exp_ready = er; t.exp_rv = ev; t.exp_rdata = ed;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.req_valid = v.valid;
    bus.req_we    = v.we;
    bus.req_wmask = v.wmask;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.rsp_ready = v.rsp_ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
    checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(v.exp_rv));
    checkOutput({tag, " sram_we"}, 32'(sram_we), 32'(v.valid & v.we & v.exp_ready));
    checkOutput({tag, " sram_addr"}, 32'(sram_addr), 32'(v.addr));
    if (v.exp_rv) checkOutput({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // write/read same address, single response
    vecs.push_back(mk(1, 1, 1, 12'h0A5, 8'h3C, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'h0A5, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    // address extremes, back-to-back reads
    vecs.push_back(mk(1, 1, 1, 12'h000, 8'h11, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 12'hFFF, 8'hFF, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'hFFF, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'h11));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    // zero-mask write leaves old data
    vecs.push_back(mk(1, 1, 1, 12'h010, 8'hAA, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 12'h010, 8'h55, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'h010, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'hAA));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    // backpressure: third read waits for the first pop
    vecs.push_back(mk(1, 0, 1, 12'h0A5, 8'h00, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'hFFF, 8'h00, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'h000, 8'h00, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(1, 0, 1, 12'h000, 8'h00, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(1, 0, 1, 12'h000, 8'h00, 1, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'h11));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    // write in the capture cycle of a read to the same address
    vecs.push_back(mk(1, 0, 1, 12'h0A5, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 12'h0A5, 8'h77, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 12'h0A5, 8'h00, 1, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 1, 8'h77));
    vecs.push_back(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));

    rstb = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wmask = '1;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset sram_we", 32'(sram_we), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkRow($sformatf("vec%0d", i), vecs[i]);
    end

    // reset while a read is in flight drops it
    applyStimulus(mk(1, 0, 1, 12'h0A5, 8'h00, 1, 1, 0, 8'h00));
    #1;
    checkOutput("midrst read accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rstb = 1'b0;
    bus.req_we = 1'b1;
    #1;
    checkOutput("midrst req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("midrst sram_we", 32'(sram_we), 32'd0);
    checkOutput("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    #1;
    checkOutput("post-rst req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post-rst rsp_valid c%0d", i), 32'(bus.rsp_valid), 32'd0);
    end

`ifdef SRAM22_REQ_ADAPTER_STATS_EN
    @(negedge clk);
    rstb = 1'b0;
    #1;
    checkOutput("stats reset rd_count", 32'(rd_count), 32'd0);
    checkOutput("stats reset wr_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(mk(1, 0, 1, 12'(i), 8'h00, 1, 1, 0, 8'h00));
    for (int i = 0; i < 3; i++) applyStimulus(mk(1, 1, 1, 12'(i), 8'h5A, 1, 1, 0, 8'h00));
    applyStimulus(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    repeat (2) @(negedge clk);
    #1;
    checkOutput("stats rd_count", 32'(rd_count), 32'd5);
    checkOutput("stats wr_count", 32'(wr_count), 32'd3);
    for (int i = 0; i < 65540; i++) applyStimulus(mk(1, 1, 1, 12'h100, 8'h00, 1, 1, 0, 8'h00));
    applyStimulus(mk(0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00));
    #1;
    checkOutput("stats wr_count sat", 32'(wr_count), 32'h0000FFFF);
    checkOutput("stats rd_count hold", 32'(rd_count), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
